bus_drive_decoder: RTL and testbench
====================================

BUS_DRIVE_DECODER -- requirements
Module: bus_drive_decoder

Interface
REQ-001 The block SHALL have parameter MIN_HOLD, default 2, giving the minimum number of cycles a granted source drives the bus (legal 1..15).
REQ-002 The block SHALL have parameter TURN_CYCLES, default 1, giving the number of dead cycles after a release (legal 1..7).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port clr, input, 1, the reset: asynchronous and active-high.
REQ-005 The block SHALL have port sel_in, input, 5, the binary code of the bus source to enable (0..31).
REQ-006 The block SHALL have port sel_valid, input, 1, which requests a grant for sel_in.
REQ-007 The block SHALL have port release, input, 1, which asks to end the current grant.
REQ-008 The block SHALL have port drive_en, output, 32, the one-hot bus-driver enables (bit n enables source n).
REQ-009 The block SHALL have port cur_sel, output, 5, the code of the most recently granted source.
REQ-010 The block SHALL have port busy, output, 1, which is high whenever the state is not IDLE.
REQ-011 The block SHALL have port grant, output, 1, a one-cycle pulse in the first cycle drive_en is non-zero for a new grant.
REQ-012 The block SHALL have port err, output, 1, a one-cycle pulse flagging a rejected request.

Function
REQ-013 The block SHALL implement the states IDLE, DRIVE and TURN, with all outputs registered.
REQ-014 In IDLE with sel_valid=1, the block SHALL at the next edge latch sel_in into cur_sel, set drive_en = 1 << sel_in, pulse grant, load hold_cnt=1 and enter DRIVE (latency 1 cycle).
REQ-015 In DRIVE, drive_en SHALL hold exactly one bit set, hold_cnt SHALL increment each cycle, saturating at MIN_HOLD, and a release seen while hold_cnt < MIN_HOLD SHALL set a pending flag.
REQ-016 DRIVE SHALL exit at the edge where (release or pending)=1 and hold_cnt >= MIN_HOLD; that edge clears drive_en to 0 and clears pending.
REQ-017 Without release, DRIVE SHALL persist indefinitely with drive_en unchanged.
REQ-018 TURN SHALL keep drive_en=0 and busy=1 for exactly TURN_CYCLES cycles, counted by turn_cnt, then enter IDLE.
REQ-019 sel_valid=1 in DRIVE or TURN SHALL be ignored (no change to drive_en/cur_sel) and SHALL pulse err at the next edge; held sel_valid SHALL pulse err every such cycle.
REQ-020 sel_valid and release high together in IDLE SHALL grant as REQ-014; that release SHALL NOT be retained.
REQ-021 release in IDLE or TURN SHALL be ignored without error.
REQ-022 drive_en SHALL never have more than one bit set, and SHALL never go directly from one non-zero value to a different one.
REQ-023 cur_sel SHALL retain its value through TURN and IDLE until the next grant.

Reset
REQ-024 clr=1 SHALL immediately force state=IDLE, drive_en=0, cur_sel=0, busy=0, grant=0, err=0, pending=0, hold_cnt=0 and turn_cnt=0, regardless of clk.
REQ-025 Reset asserted mid-DRIVE or mid-TURN SHALL abandon the operation; the first request after clr falls SHALL be granted per REQ-014.

Configuration
REQ-026 Macro BUS_DRIVE_DEAD_CYCLE_EN SHALL control the TURN state.
REQ-027 With BUS_DRIVE_DEAD_CYCLE_EN defined, TURN SHALL be present per REQ-018.
REQ-028 Without BUS_DRIVE_DEAD_CYCLE_EN, DRIVE SHALL exit directly to IDLE (busy=0 the cycle after drive_en clears), the TURN state, turn_cnt and TURN_CYCLES SHALL be unused, and all other behaviour SHALL be unchanged.

Verification
REQ-029 Scenario: after reset, sel_in=5 with sel_valid for 1 cycle -> next cycle drive_en=32'h00000020, cur_sel=5, grant=1 for one cycle, busy=1.
REQ-030 Scenario: grant sel=31, release in the first DRIVE cycle (MIN_HOLD=2) -> drive_en=32'h80000000 for exactly 2 cycles, then 0 for 1 TURN cycle, then busy=0.
REQ-031 Scenario: during DRIVE of sel=3, sel_valid with sel_in=9 -> err pulses 1 cycle and drive_en stays 32'h00000008.
REQ-032 Scenario: sel=0 granted, then released; sel_valid sel=1 held throughout TURN -> err each TURN cycle, then drive_en=32'h00000002 one cycle after IDLE is reached, with no overlapping bits at any edge.
REQ-033 Scenario: clr pulsed asynchronously mid-DRIVE of sel=17 -> drive_en=0 and busy=0 before the next clk edge; a later request for sel=17 is granted normally.
REQ-034 Scenario: build without BUS_DRIVE_DEAD_CYCLE_EN, release sel=4 -> drive_en goes 32'h00000010 then 0 with busy=0 on the same edge; a new sel_valid the next cycle is granted.

Source files
------------

// File: rtl/bus_drive_decoder.sv
// rtl/bus_drive_decoder.sv - one-hot bus driver enable decoder with minimum hold and turnaround.
// Define BUS_DRIVE_DEAD_CYCLE_EN to insert TURN_CYCLES dead cycles after each release.
module bus_drive_decoder #(
  parameter int MIN_HOLD    = 2,
  parameter int TURN_CYCLES = 1
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [4:0]  sel_in,
  input  logic        sel_valid,
  input  logic        release_req,
  output logic [31:0] drive_en,
  output logic [4:0]  cur_sel,
  output logic        busy,
  output logic        grant,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    TURN  = 2'd2
  } state_t;

  localparam logic [3:0] HOLD_MAX = 4'(MIN_HOLD);
  localparam logic [2:0] TURN_MAX = 3'(TURN_CYCLES);

  state_t      state, state_n;
  logic [31:0] drive_en_n;
  logic [4:0]  cur_sel_n;
  logic        busy_n, grant_n, err_n;
  logic        pending, pending_n;
  logic [3:0]  hold_cnt, hold_cnt_n;
  logic [2:0]  turn_cnt, turn_cnt_n;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state    <= IDLE;
      drive_en <= '0;
      cur_sel  <= '0;
      busy     <= 1'b0;
      grant    <= 1'b0;
      err      <= 1'b0;
      pending  <= 1'b0;
      hold_cnt <= '0;
      turn_cnt <= '0;
    end else begin
      state    <= state_n;
      drive_en <= drive_en_n;
      cur_sel  <= cur_sel_n;
      busy     <= busy_n;
      grant    <= grant_n;
      err      <= err_n;
      pending  <= pending_n;
      hold_cnt <= hold_cnt_n;
      turn_cnt <= turn_cnt_n;
    end
  end

  always_comb begin
    state_n    = state;
    drive_en_n = drive_en;
    cur_sel_n  = cur_sel;
    grant_n    = 1'b0;
    err_n      = 1'b0;
    pending_n  = pending;
    hold_cnt_n = hold_cnt;
    turn_cnt_n = turn_cnt;
    case (state)
      IDLE: begin
        if (sel_valid) begin
          state_n    = DRIVE;
          cur_sel_n  = sel_in;
          drive_en_n = 32'd1 << sel_in;
          grant_n    = 1'b1;
          hold_cnt_n = 4'd1;
          pending_n  = 1'b0;
        end
      end
      DRIVE: begin
        err_n = sel_valid;
        if ((release_req || pending) && (hold_cnt >= HOLD_MAX)) begin
          // Always pass through all-zero so two sources never share an edge.
          drive_en_n = '0;
          pending_n  = 1'b0;
`ifdef BUS_DRIVE_DEAD_CYCLE_EN
          state_n    = TURN;
          turn_cnt_n = 3'd1;
`else
          state_n    = IDLE;
`endif
        end else if (hold_cnt < HOLD_MAX) begin
          hold_cnt_n = hold_cnt + 4'd1;
          if (release_req) pending_n = 1'b1;
        end
      end
      TURN: begin
        err_n = sel_valid;
        if (turn_cnt >= TURN_MAX) state_n = IDLE;
        else turn_cnt_n = turn_cnt + 3'd1;
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_bus_drive_decoder.sv
// tb/tb_bus_drive_decoder.sv - scoreboard bench for bus_drive_decoder (directed vectors).
module tb_bus_drive_decoder;

`ifdef BUS_DRIVE_DEAD_CYCLE_EN
  localparam int TC = 1;
`else
  localparam int TC = 0;
`endif

  localparam int EV_GRANT = 0;
  localparam int EV_ERR   = 1;
  localparam int EV_DROP  = 2;
  localparam int EV_IDLE  = 3;

  logic        clk = 1'b0;
  logic        clr;
  logic [4:0]  sel_in;
  logic        sel_valid;
  logic        release_req;
  logic [31:0] drive_en;
  logic [4:0]  cur_sel;
  logic        busy, grant, err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int          kind;
    int          cyc;
    logic [31:0] de;
    logic [4:0]  cs;
    logic        busy;
  } ev_t;

  ev_t exp_q[$];

  logic [31:0] prev_de   = '0;
  logic        prev_busy = 1'b0;
  bit          clr_seen  = 1'b0;

  bus_drive_decoder #(.MIN_HOLD(2), .TURN_CYCLES(1)) dut (
    .clk(clk), .clr(clr), .sel_in(sel_in), .sel_valid(sel_valid), .release_req(release_req),
    .drive_en(drive_en), .cur_sel(cur_sel), .busy(busy), .grant(grant), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clr) clr_seen = 1'b1;

  function automatic string kind_name(input int k);
    case (k)
      EV_GRANT: return "grant";
      EV_ERR:   return "err";
      EV_DROP:  return "drop";
      default:  return "idle";
    endcase
  endfunction

  task automatic push(input int k, input int c, input logic [31:0] d, input logic [4:0] s, input logic b);
    ev_t e;
    int  idx;
    e.kind = k; e.cyc = c; e.de = d; e.cs = s; e.busy = b;
    idx = exp_q.size();
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].cyc > c || (exp_q[i].cyc == c && exp_q[i].kind > k)) idx = i;
    end
    exp_q.insert(idx, e);
  endtask

  task automatic expect_ev(input int k);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_%s actual cyc=%0d de=%h cs=%0d busy=%b required none", kind_name(k), cyc, drive_en, cur_sel, busy);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.cyc != cyc || e.de !== drive_en || e.cs !== cur_sel || e.busy !== busy) begin
        errors++;
        $display("FAIL event actual %s cyc=%0d de=%h cs=%0d busy=%b required %s cyc=%0d de=%h cs=%0d busy=%b",
                 kind_name(k), cyc, drive_en, cur_sel, busy, kind_name(e.kind), e.cyc, e.de, e.cs, e.busy);
      end
    end
  endtask

  always @(negedge clk) begin
    if (clr || clr_seen) begin
      clr_seen = 1'b0;
    end else begin
      checks++;
      if (!$onehot0(drive_en)) begin
        errors++;
        $display("FAIL onehot actual=%h required at most one bit", drive_en);
      end
      checks++;
      if (prev_de != 0 && drive_en != 0 && drive_en != prev_de) begin
        errors++;
        $display("FAIL direct_switch actual=%h->%h required pass through 0", prev_de, drive_en);
      end
      if (grant) expect_ev(EV_GRANT);
      if (err) expect_ev(EV_ERR);
      if (prev_de != 0 && drive_en == 0) expect_ev(EV_DROP);
      if (prev_busy && !busy) expect_ev(EV_IDLE);
    end
    prev_de   = drive_en;
    prev_busy = busy;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic grant_src(input logic [4:0] s);
    sel_in = s;
    sel_valid = 1'b1;
    push(EV_GRANT, cyc + 1, 32'd1 << s, s, 1'b1);
    @(negedge clk);
    sel_valid = 1'b0;
  endtask

  task automatic release_src(input logic [4:0] s, input int lat);
    release_req = 1'b1;
    push(EV_DROP, cyc + lat, 32'd0, s, TC > 0);
    push(EV_IDLE, cyc + lat + TC, 32'd0, s, 1'b0);
    @(negedge clk);
    release_req = 1'b0;
  endtask

  initial begin
    clr = 1'b1; sel_in = '0; sel_valid = 1'b0; release_req = 1'b0;
    @(negedge clk);
    check("reset_drive_en", drive_en, 32'd0);
    check("reset_cur_sel", {27'd0, cur_sel}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_grant", {31'd0, grant}, 32'd0);
    check("reset_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);

    // Basic grant of source 5, held past MIN_HOLD, then released.
    grant_src(5'd5);
    idle_cycles(3);
    release_src(5'd5, 1);
    idle_cycles(3);

    // Release in the first DRIVE cycle is deferred until MIN_HOLD is met.
    grant_src(5'd31);
    release_src(5'd31, 2);
    idle_cycles(4);

    // Requests during DRIVE are rejected every cycle they are held.
    grant_src(5'd3);
    idle_cycles(1);
    sel_in = 5'd9;
    sel_valid = 1'b1;
    push(EV_ERR, cyc + 1, 32'h0000_0008, 5'd3, 1'b1);
    push(EV_ERR, cyc + 2, 32'h0000_0008, 5'd3, 1'b1);
    idle_cycles(2);
    sel_valid = 1'b0;
    idle_cycles(1);
    release_src(5'd3, 1);
    idle_cycles(3);

    // Request held across the turnaround is granted once IDLE is reached.
    grant_src(5'd0);
    idle_cycles(2);
    release_src(5'd0, 1);
    sel_in = 5'd1;
    sel_valid = 1'b1;
`ifdef BUS_DRIVE_DEAD_CYCLE_EN
    push(EV_ERR, cyc + 1, 32'd0, 5'd0, 1'b0);
    push(EV_GRANT, cyc + 2, 32'h0000_0002, 5'd1, 1'b1);
    idle_cycles(2);
`else
    push(EV_GRANT, cyc + 1, 32'h0000_0002, 5'd1, 1'b1);
    idle_cycles(1);
`endif
    sel_valid = 1'b0;
    idle_cycles(1);
    release_src(5'd1, 1);
    idle_cycles(3);

    // Asynchronous clear mid-DRIVE, then a normal re-grant.
    grant_src(5'd17);
    idle_cycles(1);
    #2 clr = 1'b1;
    #1;
    check("async_clr_drive_en", drive_en, 32'd0);
    check("async_clr_busy", {31'd0, busy}, 32'd0);
    check("async_clr_cur_sel", {27'd0, cur_sel}, 32'd0);
    #1 clr = 1'b0;
    idle_cycles(2);
    grant_src(5'd17);
    idle_cycles(2);
    release_src(5'd17, 1);
    idle_cycles(3);

    // Release alone in IDLE is ignored; release alongside a request is not retained.
    release_req = 1'b1;
    idle_cycles(1);
    release_req = 1'b0;
    idle_cycles(2);
    sel_in = 5'd12;
    sel_valid = 1'b1;
    release_req = 1'b1;
    push(EV_GRANT, cyc + 1, 32'h0000_1000, 5'd12, 1'b1);
    idle_cycles(1);
    sel_valid = 1'b0;
    release_req = 1'b0;
    idle_cycles(5);
    check("persist_drive_en", drive_en, 32'h0000_1000);
    release_src(5'd12, 1);
    idle_cycles(4);

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
